// File: rtl/fifo_pointer_ctrl.sv
// One side of an asynchronous FIFO: binary/Gray pointer, RAM bit address, and
// occupancy/flags computed against the other domain's synchronised Gray pointer.
module fifo_pointer_ctrl #(
    parameter int DATA_WIDTH       = 8,
    parameter int DEPTH            = 8,
    parameter bit IS_WRITE_SIDE    = 1'b1,
    parameter int ALMOST_THRESHOLD = 2,
    localparam int AW  = $clog2(DEPTH),
    localparam int ADW = $clog2(DATA_WIDTH * DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          clear,
    input  logic [AW:0]   remote_pointer_gray,
    output logic          accepted,
    output logic [AW-1:0] pointer,
    output logic [ADW-1:0] address,
    output logic [AW:0]   pointer_gray,
    output logic [AW:0]   level,
    output logic          flag,
    output logic          almost_flag
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_pointer_ctrl: DEPTH must be a power of two and at least 2");
    end
    if (ALMOST_THRESHOLD < 0 || ALMOST_THRESHOLD > DEPTH) begin : g_bad_threshold
        $error("fifo_pointer_ctrl: ALMOST_THRESHOLD must lie in 0..DEPTH");
    end

    localparam logic [ADW-1:0] ADDR_STEP          = ADW'(DATA_WIDTH);
    localparam logic [ADW-1:0] ADDR_LAST          = ADW'(DATA_WIDTH * (DEPTH - 1));
    localparam logic [AW:0]    FULL_LEVEL         = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    ALMOST_FULL_LEVEL  = (AW + 1)'(DEPTH - ALMOST_THRESHOLD);
    localparam logic [AW:0]    ALMOST_EMPTY_LEVEL = (AW + 1)'(ALMOST_THRESHOLD);

    logic [AW:0]    bin;
    logic [AW:0]    next_bin;
    logic [AW:0]    remote_bin;
    logic [ADW-1:0] flush_address;
    logic           flush;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        remote_bin = '0;
        for (int i = 0; i <= AW; i++) begin
            remote_bin[i] = ^(remote_pointer_gray >> i);
        end
    end

    always_comb begin
        if (IS_WRITE_SIDE) begin
            level       = bin - remote_bin;
            flag        = (level == FULL_LEVEL);
            almost_flag = (level >= ALMOST_FULL_LEVEL);
        end else begin
            level       = remote_bin - bin;
            flag        = (level == '0);
            almost_flag = (level <= ALMOST_EMPTY_LEVEL);
        end
    end

    assign flush         = !IS_WRITE_SIDE && clear;
    assign accepted      = enable && !flag && !flush;
    assign next_bin      = bin + 1'b1;
    assign flush_address = ADW'(remote_bin[AW-1:0] * DATA_WIDTH);
    assign pointer       = bin[AW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            bin          <= '0;
            address      <= '0;
            pointer_gray <= '0;
        end else if (flush) begin
            bin          <= remote_bin;
            address      <= flush_address;
            pointer_gray <= remote_pointer_gray;
        end else if (accepted) begin
            bin          <= next_bin;
            // Address runs as its own counter so the increment path needs no multiplier.
            address      <= (address == ADDR_LAST) ? '0 : address + ADDR_STEP;
            pointer_gray <= next_bin ^ (next_bin >> 1);
        end
    end

endmodule

// File: tb/tb_fifo_pointer_ctrl.sv
// Directed bench for fifo_pointer_ctrl: one write-side and one read-side instance
// (DEPTH=8, DATA_WIDTH=8, ALMOST_THRESHOLD=2) checked against hand-computed values.
module tb_fifo_pointer_ctrl;

    logic clk;
    logic reset;

    logic       wr_enable, wr_clear, wr_accepted, wr_flag, wr_almost;
    logic [3:0] wr_remote, wr_gray, wr_level;
    logic [2:0] wr_pointer;
    logic [5:0] wr_address;

    logic       rd_enable, rd_clear, rd_accepted, rd_flag, rd_almost;
    logic [3:0] rd_remote, rd_gray, rd_level;
    logic [2:0] rd_pointer;
    logic [5:0] rd_address;

    int checks   = 0;
    int failures = 0;

    // Gray codes of binary pointers 0..8 and of 6..16 (16 wraps to 0).
    logic [3:0] exp_fill [9]  = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    logic [3:0] exp_wrap [11] = '{4'h5, 4'h4, 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    fifo_pointer_ctrl #(
        .DATA_WIDTH(8), .DEPTH(8), .IS_WRITE_SIDE(1'b1), .ALMOST_THRESHOLD(2)
    ) dut_wr (
        .clk(clk), .reset(reset), .enable(wr_enable), .clear(wr_clear),
        .remote_pointer_gray(wr_remote), .accepted(wr_accepted), .pointer(wr_pointer),
        .address(wr_address), .pointer_gray(wr_gray), .level(wr_level),
        .flag(wr_flag), .almost_flag(wr_almost)
    );

    fifo_pointer_ctrl #(
        .DATA_WIDTH(8), .DEPTH(8), .IS_WRITE_SIDE(1'b0), .ALMOST_THRESHOLD(2)
    ) dut_rd (
        .clk(clk), .reset(reset), .enable(rd_enable), .clear(rd_clear),
        .remote_pointer_gray(rd_remote), .accepted(rd_accepted), .pointer(rd_pointer),
        .address(rd_address), .pointer_gray(rd_gray), .level(rd_level),
        .flag(rd_flag), .almost_flag(rd_almost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] prev;
        int n;

        reset     = 1'b0;
        wr_enable = 1'b0; wr_clear = 1'b0; wr_remote = '0;
        rd_enable = 1'b0; rd_clear = 1'b0; rd_remote = '0;
        #12 reset = 1'b1;
        #1;

        check("wr_rst_pointer", wr_pointer, 0);
        check("wr_rst_address", wr_address, 0);
        check("wr_rst_gray",    wr_gray,    0);
        check("wr_rst_level",   wr_level,   0);
        check("wr_rst_flag",    wr_flag,    0);
        check("wr_rst_almost",  wr_almost,  0);
        check("rd_rst_level",   rd_level,   0);
        check("rd_rst_flag",    rd_flag,    1);
        check("rd_rst_almost",  rd_almost,  1);

        // Write fill: 8 accepts, then two blocked cycles.
        wr_enable = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            n = (k < 8) ? k : 8;
            check($sformatf("fill_level_%0d", k),    wr_level,    n);
            check($sformatf("fill_flag_%0d", k),     wr_flag,     (n == 8));
            check($sformatf("fill_almost_%0d", k),   wr_almost,   (n >= 6));
            check($sformatf("fill_accepted_%0d", k), wr_accepted, (k < 8));
            check($sformatf("fill_gray_%0d", k),     wr_gray,     exp_fill[n]);
            check($sformatf("fill_address_%0d", k),  wr_address,  (n % 8) * 8);
            check($sformatf("fill_pointer_%0d", k),  wr_pointer,  n % 8);
            step();
        end
        check("fill_held_gray",  wr_gray,     4'hC);
        check("fill_held_flag",  wr_flag,     1);
        check("fill_held_accpt", wr_accepted, 0);

        // Remote release to bin 3: flag clears the same cycle, held enable goes next edge.
        wr_remote = 4'h2;
        #1;
        check("release_level",    wr_level,    5);
        check("release_flag",     wr_flag,     0);
        check("release_almost",   wr_almost,   0);
        check("release_accepted", wr_accepted, 1);
        step();
        check("release_pointer", wr_pointer, 1);
        check("release_address", wr_address, 8);
        check("release_gray",    wr_gray,    4'hD);
        check("release_level2",  wr_level,   6);
        check("release_almost2", wr_almost,  1);

        // clear has no effect on the write side.
        wr_clear = 1'b1;
        #1;
        check("wr_clear_accepted", wr_accepted, 1);
        step();
        check("wr_clear_gray",  wr_gray,  4'hF);
        check("wr_clear_level", wr_level, 7);
        wr_enable = 1'b0;
        wr_clear  = 1'b0;

        // Read drain against remote bin 5.
        rd_remote = 4'h7;
        rd_enable = 1'b1;
        #1;
        for (int k = 0; k < 7; k++) begin
            n = (k < 5) ? k : 5;
            check($sformatf("drain_level_%0d", k),    rd_level,    5 - n);
            check($sformatf("drain_accepted_%0d", k), rd_accepted, (n < 5));
            check($sformatf("drain_flag_%0d", k),     rd_flag,     (n == 5));
            check($sformatf("drain_almost_%0d", k),   rd_almost,   ((5 - n) <= 2));
            check($sformatf("drain_pointer_%0d", k),  rd_pointer,  n);
            step();
        end
        check("drain_gray",    rd_gray,    4'h7);
        check("drain_address", rd_address, 40);

        // Wrap: remote to bin 13, drain 8, then remote to bin 16 (=0), drain 3.
        rd_remote = 4'hB;
        #1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("wrap_level_%0d", k),    rd_level,    8 - k);
            check($sformatf("wrap_accepted_%0d", k), rd_accepted, 1);
            prev = rd_gray;
            step();
            check($sformatf("wrap_gray_%0d", k),   rd_gray, exp_wrap[k]);
            check($sformatf("wrap_onebit_%0d", k), $countones(prev ^ rd_gray), 1);
        end
        check("wrap_mid_flag",     rd_flag,     1);
        check("wrap_mid_accepted", rd_accepted, 0);
        rd_remote = 4'h0;
        #1;
        check("wrap_remote0_level", rd_level, 3);
        check("wrap_remote0_flag",  rd_flag,  0);
        for (int k = 8; k < 11; k++) begin
            prev = rd_gray;
            step();
            check($sformatf("wrap_gray_%0d", k),   rd_gray, exp_wrap[k]);
            check($sformatf("wrap_onebit_%0d", k), $countones(prev ^ rd_gray), 1);
        end
        check("wrap_end_pointer", rd_pointer, 0);
        check("wrap_end_address", rd_address, 0);
        check("wrap_end_wrapbit", rd_gray[3], 0);
        check("wrap_end_flag",    rd_flag,    1);

        // Flush: advance read side to bin 2, then clear against remote bin 13.
        rd_remote = 4'h3;
        step();
        step();
        check("flush_pre_pointer", rd_pointer, 2);
        rd_remote = 4'hB;
        rd_clear  = 1'b1;
        #1;
        check("flush_accepted", rd_accepted, 0);
        step();
        rd_clear  = 1'b0;
        rd_enable = 1'b0;
        #1;
        check("flush_pointer", rd_pointer, 5);
        check("flush_address", rd_address, 40);
        check("flush_gray",    rd_gray,    4'hB);
        check("flush_level",   rd_level,   0);
        check("flush_flag",    rd_flag,    1);

        // Reset mid-operation with write side at bin 6.
        reset = 1'b0;
        #1 reset = 1'b1;
        wr_remote = 4'h0;
        wr_enable = 1'b1;
        repeat (6) step();
        wr_enable = 1'b0;
        #1;
        check("midrst_pre_pointer", wr_pointer, 6);
        check("midrst_pre_address", wr_address, 48);
        #1 reset = 1'b0;
        #1;
        check("midrst_pointer", wr_pointer, 0);
        check("midrst_address", wr_address, 0);
        check("midrst_gray",    wr_gray,    0);
        check("midrst_level",   wr_level,   0);
        check("midrst_flag",    wr_flag,    0);
        #1 reset = 1'b1;
        wr_enable = 1'b1;
        step();
        check("post_rst_pointer", wr_pointer, 1);
        check("post_rst_address", wr_address, 8);
        check("post_rst_gray",    wr_gray,    4'h1);
        wr_enable = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
